// File: rtl/rd_port_fwft.sv
// Read-domain port of the async FIFO: binary/Gray read pointer, empty detect and a
// 2-entry first-word-fall-through output buffer. Optional rd_level via FIFO_RD_LEVEL_EN.
module rd_port_fwft #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH:0]    wptr_sync,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              r_en,
  output logic [WIDTH-1:0]  r_addr,
  output logic [WIDTH:0]    rptr,
  output logic              empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [WIDTH:0]    rd_level
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e              occ_q, occ_d;
  logic [1:0]        occ_cnt;
  logic              infl_q;
  logic [WIDTH:0]    rbin_q, rbin_d;
  logic [WIDTH:0]    rptr_q;
  logic [DATA_W-1:0] buf_q [2];
  logic              head_q;
  logic              pop;
  logic [2:0]        fill_after;

  assign occ_cnt = occ_q;
  assign r_addr  = rbin_q[WIDTH-1:0];
  assign rptr    = rptr_q;
  assign empty   = (rptr_q == wptr_sync);

  // The word arriving from RAM is presented directly while the buffer is empty,
  // which gives one-cycle fetch-to-valid latency and 1 word/cycle streaming.
  assign m_valid = (occ_q != EMPTY) || infl_q;
  assign m_data  = (occ_q == EMPTY && infl_q) ? mem_rdata : buf_q[head_q];

  always_comb begin
    pop        = m_valid && m_ready;
    fill_after = {1'b0, occ_cnt} + {2'b00, infl_q} - {2'b00, pop};
    r_en       = !empty && (fill_after < 3'd2);
    rbin_d     = rbin_q + {{WIDTH{1'b0}}, r_en};
    case (fill_after)
      3'd0:    occ_d = EMPTY;
      3'd1:    occ_d = ONE;
      default: occ_d = TWO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rbin_q <= '0;
      rptr_q <= '0;
      infl_q <= 1'b0;
      occ_q  <= EMPTY;
      head_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      rbin_q <= rbin_d;
      rptr_q <= rbin_d ^ (rbin_d >> 1);
      infl_q <= r_en;
      occ_q  <= occ_d;
      // Tail slot is head+occ; a word consumed straight off the bypass is written
      // to the head slot but never counted, so it is harmlessly overwritten later.
      if (infl_q) begin
        buf_q[head_q ^ occ_cnt[0]] <= mem_rdata;
      end
      if (pop && occ_q != EMPTY) begin
        head_q <= ~head_q;
      end
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [WIDTH:0] rd_level_q;

  function automatic logic [WIDTH:0] gray2bin(input logic [WIDTH:0] g);
    logic [WIDTH:0] b;
    b[WIDTH] = g[WIDTH];
    for (int unsigned i = 0; i < WIDTH; i++) begin
      b[WIDTH-1-i] = b[WIDTH-i] ^ g[WIDTH-1-i];
    end
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_level_q <= '0;
    end else begin
      rd_level_q <= gray2bin(wptr_sync) - rbin_d;
    end
  end

  assign rd_level = rd_level_q;
`endif

endmodule

// File: tb/tb_rd_port_fwft.sv
// Directed bench for rd_port_fwft with a registered-RAM model and a pop monitor.
module tb_rd_port_fwft;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] wptr_sync;
  logic [7:0] mem_rdata = '0;
  logic       r_en;
  logic [3:0] r_addr;
  logic [4:0] rptr;
  logic       empty;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_RD_LEVEL_EN
  logic [4:0] rd_level;
`endif

  logic [7:0] mem [16];
  int         wcnt;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         rd_idx  = 0;
  int         ren_cnt = 0;
  int         msb_tog = 0;
  int         base;
  logic       mon_en  = 1'b0;
  logic       hold_armed = 1'b0;
  logic [7:0] hold_data  = '0;
  logic [4:0] prev_rptr  = '0;
  logic       done;

  rd_port_fwft #(.WIDTH(4), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wptr_sync (wptr_sync),
    .mem_rdata (mem_rdata),
    .r_en      (r_en),
    .r_addr    (r_addr),
    .rptr      (rptr),
    .empty     (empty),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level  (rd_level)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (r_en) mem_rdata <= mem[r_addr];
  end

  function automatic logic [7:0] data_of(input int k);
    return 8'(k * 13 + 5);
  endfunction

  function automatic logic [4:0] bin2gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int n);
    for (int j = 0; j < n; j++) begin
      mem[4'(wcnt)] = data_of(wcnt);
      wcnt++;
    end
    wptr_sync = bin2gray(5'(wcnt));
  endtask

  // Monitor: data order on every pop, hold-while-stalled, Gray single-bit steps.
  always @(negedge clk) begin
    if (reset) begin
      rd_idx     = 0;
      hold_armed = 1'b0;
      prev_rptr  = '0;
    end else if (mon_en) begin
      if (m_valid && m_ready) begin
        check("pop_data", m_data, data_of(rd_idx));
        rd_idx++;
      end
      if (hold_armed) check("hold", {m_valid, m_data}, {1'b1, hold_data});
      hold_armed = m_valid && !m_ready;
      hold_data  = m_data;
      if (r_en) ren_cnt++;
      if (rptr != prev_rptr) begin
        check("gray_1bit", $countones(rptr ^ prev_rptr), 1);
        if (rptr[4] != prev_rptr[4]) msb_tog++;
      end
      prev_rptr = rptr;
    end
  end

  initial begin
    reset = 1'b1; wptr_sync = '0; m_ready = 1'b0; wcnt = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_empty", empty, 1);
      check("rst_ren",   r_en, 0);
      check("rst_valid", m_valid, 0);
      check("rst_rptr",  rptr, 0);
      if (i == 0) check("rst_mdata", m_data, 0);
    end
    mon_en = 1'b1;

    // Three words, consumer ready
    @(posedge clk); #1 m_ready = 1'b1; push(3);
    @(negedge clk); check("t2_ren0", r_en, 1); check("t2_v0", m_valid, 0); check("t2_addr0", r_addr, 0);
    @(negedge clk); check("t2_ren1", r_en, 1); check("t2_v1", m_valid, 1); check("t2_d1", m_data, data_of(0));
    @(negedge clk); check("t2_ren2", r_en, 1); check("t2_d2", m_data, data_of(1));
    @(negedge clk); check("t2_ren3", r_en, 0); check("t2_d3", m_data, data_of(2));
    check("t2_empty", empty, 1); check("t2_rptr", rptr, 5'b00010);
    @(negedge clk); check("t2_v4", m_valid, 0);

    // Five words, consumer stalled: only two fetches
    @(posedge clk); #1 m_ready = 1'b0; base = ren_cnt; push(5);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) check("t3_ren0", r_en, 1);
      if (i >= 1) begin
        check("t3_valid", m_valid, 1);
        check("t3_data", m_data, data_of(3));
      end
`ifdef FIFO_RD_LEVEL_EN
      if (i == 3) check("t3_level", rd_level, 3);
`endif
    end
    @(posedge clk); #1 check("t3_rencnt", ren_cnt - base, 2);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_drain_valid", m_valid, (i < 5) ? 1 : 0);
    end
    @(posedge clk); #1 check("t3_count", rd_idx, 8);

    // Stream 40 words across pointer wrap
    base = msb_tog;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1 push(1);
    end
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (empty && !m_valid) done = 1'b1;
    end
    check("t4_drain_timeout", done, 1);
    check("t4_count", rd_idx, 48);
    check("t4_msb_toggles", msb_tog - base, 3);
    check("t4_rptr", rptr, 5'b11000);

    // Reset with buffer full and a word in flight
    @(posedge clk); #1 m_ready = 1'b0; push(5);
    @(negedge clk); check("t5_ren0", r_en, 1);
    @(negedge clk); check("t5_ren1", r_en, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; wcnt = 0; wptr_sync = '0;
    @(negedge clk);
    check("t5_valid", m_valid, 0);
    check("t5_rptr",  rptr, 0);
    check("t5_empty", empty, 1);
    check("t5_mdata", m_data, 0);
    check("t5_ren",   r_en, 0);

    // Recovery after reset
    @(posedge clk); #1 m_ready = 1'b1; push(2);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 check("t6_count", rd_idx, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
